// File: rtl/mxint_pkg.sv
// rtl/mxint_pkg.sv - shared MxInt helpers: max() and accumulator mantissa width
package mxint_pkg;

    function automatic int max(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Width of a mantissa after summing depth blocks; mxint_cast sizes its input from this.
    function automatic int acc_man_width(input int man_width, input int depth);
        return man_width + $clog2(depth);
    endfunction

endpackage

// File: rtl/mxint_align_add.sv
// rtl/mxint_align_add.sv - aligns an accumulator block and an input block to the larger exponent and adds them
module mxint_align_add
    import mxint_pkg::*;
#(
    parameter int IN_W       = 8,
    parameter int OUT_W      = 10,
    parameter int EXP_W      = 8,
    parameter int BLOCK_SIZE = 4
) (
    input  logic signed [OUT_W-1:0] i_acc_man [BLOCK_SIZE],
    input  logic        [EXP_W-1:0] i_acc_exp,
    input  logic signed [IN_W-1:0]  i_in_man  [BLOCK_SIZE],
    input  logic        [EXP_W-1:0] i_in_exp,
    output logic signed [OUT_W-1:0] o_sum_man [BLOCK_SIZE],
    output logic        [EXP_W-1:0] o_sum_exp
);

    logic             w_in_gt;
    logic [EXP_W:0]   w_diff;

    // Difference taken one bit wider so it can never wrap.
    assign w_in_gt   = i_in_exp > i_acc_exp;
    assign w_diff    = w_in_gt ? ({1'b0, i_in_exp} - {1'b0, i_acc_exp})
                               : ({1'b0, i_acc_exp} - {1'b0, i_in_exp});
    assign o_sum_exp = w_in_gt ? i_in_exp : i_acc_exp;

    function automatic logic signed [OUT_W-1:0] shift_clamp(
        input logic signed [OUT_W-1:0] v,
        input logic        [EXP_W:0]   d
    );
        if (int'(d) >= OUT_W) begin
            return v[OUT_W-1] ? '1 : '0;
        end
        return v >>> d;
    endfunction

    for (genvar g = 0; g < BLOCK_SIZE; g++) begin : g_lane
        logic signed [OUT_W-1:0] w_in_ext;
        assign w_in_ext     = OUT_W'(i_in_man[g]);
        assign o_sum_man[g] = w_in_gt ? shift_clamp(i_acc_man[g], w_diff) + w_in_ext
                                      : i_acc_man[g] + shift_clamp(w_in_ext, w_diff);
    end

endmodule

// File: rtl/mxint_accumulator.sv
// rtl/mxint_accumulator.sv - accumulates IN_DEPTH MxInt blocks element-wise into one widened block
module mxint_accumulator
    import mxint_pkg::*;
#(
    parameter int DATA_IN_MAN_WIDTH = 8,
    parameter int DATA_IN_EXP_WIDTH = 8,
    parameter int BLOCK_SIZE        = 4,
    parameter int IN_DEPTH          = 4,
    localparam int DATA_OUT_MAN_WIDTH = acc_man_width(DATA_IN_MAN_WIDTH, IN_DEPTH)
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic signed [DATA_IN_MAN_WIDTH-1:0]  mdata_in  [BLOCK_SIZE],
    input  logic        [DATA_IN_EXP_WIDTH-1:0]  edata_in,
    input  logic                                 data_in_valid,
    output logic                                 data_in_ready,
    output logic signed [DATA_OUT_MAN_WIDTH-1:0] mdata_out [BLOCK_SIZE],
    output logic        [DATA_IN_EXP_WIDTH-1:0]  edata_out,
    output logic                                 data_out_valid,
    input  logic                                 data_out_ready
);

    localparam int                CNT_W = max(1, $clog2(IN_DEPTH));
    localparam logic [CNT_W-1:0]  LAST  = CNT_W'(IN_DEPTH - 1);

    logic        [CNT_W-1:0]              r_count;
    logic                                 r_valid;
    logic signed [DATA_OUT_MAN_WIDTH-1:0] r_man [BLOCK_SIZE];
    logic        [DATA_IN_EXP_WIDTH-1:0]  r_exp;

    logic signed [DATA_OUT_MAN_WIDTH-1:0] w_sum_man [BLOCK_SIZE];
    logic        [DATA_IN_EXP_WIDTH-1:0]  w_sum_exp;
    logic                                 w_accept;

    assign data_in_ready  = !r_valid || data_out_ready;
    assign w_accept       = data_in_valid && data_in_ready;
    assign mdata_out      = r_man;
    assign edata_out      = r_exp;
    assign data_out_valid = r_valid;

    mxint_align_add #(
        .IN_W       (DATA_IN_MAN_WIDTH),
        .OUT_W      (DATA_OUT_MAN_WIDTH),
        .EXP_W      (DATA_IN_EXP_WIDTH),
        .BLOCK_SIZE (BLOCK_SIZE)
    ) u_align_add (
        .i_acc_man (r_man),
        .i_acc_exp (r_exp),
        .i_in_man  (mdata_in),
        .i_in_exp  (edata_in),
        .o_sum_man (w_sum_man),
        .o_sum_exp (w_sum_exp)
    );

    // The output registers double as the accumulator; a first block overwrites
    // them, which lets a drained result and a new group share one cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
            r_valid <= 1'b0;
            r_exp   <= '0;
            for (int i = 0; i < BLOCK_SIZE; i++) begin
                r_man[i] <= '0;
            end
        end else begin
            if (r_valid && data_out_ready) begin
                r_valid <= 1'b0;
            end
            if (w_accept) begin
                if (r_count == '0) begin
                    for (int i = 0; i < BLOCK_SIZE; i++) begin
                        r_man[i] <= DATA_OUT_MAN_WIDTH'(mdata_in[i]);
                    end
                    r_exp <= edata_in;
                end else begin
                    for (int i = 0; i < BLOCK_SIZE; i++) begin
                        r_man[i] <= w_sum_man[i];
                    end
                    r_exp <= w_sum_exp;
                end
                if (r_count == LAST) begin
                    r_count <= '0;
                    r_valid <= 1'b1;
                end else begin
                    r_count <= r_count + CNT_W'(1);
                end
            end
        end
    end

endmodule
